// File: rtl/hex_mmio_display.sv
// hex_mmio_display: memory-mapped board I/O for the hart's data bus.
// Four word registers (DATA, CTRL, LED, INPUT) drive HEX0..HEX5 and LEDR and
// expose synchronised SW/KEY. Single-cycle req/ack; all board outputs registered.
// Optional blink feature: define HEX_MMIO_DISPLAY_BLINK_EN to build the blink
// counter, phase flop and CTRL[6]; otherwise CTRL[6] reads 0 and never blanks.
module hex_mmio_display #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [9:0]  LEDR
);

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_CTRL  = 2'd1,
    REG_LED   = 2'd2,
    REG_INPUT = 2'd3
  } reg_off_e;

  // Hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Architectural registers
  logic [23:0] data_q, data_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic [9:0]  led_q,  led_d;

  // Bus response registers
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  // Two-flop synchronisers; KEY is stored inverted so 1 = pressed
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [3:0]  key_s1_q, key_s2_q;

  // Registered board outputs
  logic [6:0]  hex_q [6];
  logic [6:0]  hex_d [6];
  logic [9:0]  ledr_q;

  // Decode results
  logic        sel;
  logic        wr;
  reg_off_e    off;
  logic [31:0] rd_val;
  logic        blink_rd;
  logic        blank;

  // Inputs ignored by design (byte-lane alignment and unused data lanes)
  logic        unused_ok;
  assign unused_ok = ^{addr[1:0], wdata[31:24], wstrb[3]};

  // Address decode, read mux and register next-state from byte-strobed writes
  always_comb begin
    sel     = req && (addr[31:4] == BASE_ADDR[31:4]);
    wr      = sel && we;
    off     = reg_off_e'(addr[3:2]);
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    led_d   = led_q;
    case (off)
      REG_DATA:  rd_val = {8'h00, data_q};
      REG_CTRL:  rd_val = {25'd0, blink_rd, ctrl_q};
      REG_LED:   rd_val = {22'd0, led_q};
      default:   rd_val = {12'd0, key_s2_q, 6'd0, sw_s2_q};
    endcase
    if (wr) begin
      case (off)
        REG_DATA: begin
          if (wstrb[0]) data_d[7:0]   = wdata[7:0];
          if (wstrb[1]) data_d[15:8]  = wdata[15:8];
          if (wstrb[2]) data_d[23:16] = wdata[23:16];
        end
        REG_CTRL: begin
          if (wstrb[0]) ctrl_d = wdata[5:0];
        end
        REG_LED: begin
          if (wstrb[0]) led_d[7:0] = wdata[7:0];
          if (wstrb[1]) led_d[9:8] = wdata[9:8];
        end
        default: ;
      endcase
    end
    ack_d   = sel;
    rdata_d = sel ? rd_val : '0;
  end

`ifdef HEX_MMIO_DISPLAY_BLINK_EN
  localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          blink_q, blink_d;

  // Free-running half-period counter; phase flips on wrap, CTRL writes never touch it
  always_comb begin
    blink_d = blink_q;
    if (wr && (off == REG_CTRL) && wstrb[0]) blink_d = wdata[6];
    if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
    end
    blank    = blink_d && phase_d;
    blink_rd = blink_q;
  end

  // Blink state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end
`else
  // Without the blink feature, only the per-digit enables can blank a digit
  always_comb begin
    blank    = 1'b0;
    blink_rd = 1'b0;
  end
`endif

  // Next segment pattern; built from next-state registers so a write shows with its ack
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      hex_d[i] = (ctrl_d[i] && !blank) ? seg7(data_d[4*i +: 4]) : 7'h7F;
    end
  end

  // Registers, bus response, synchronisers and board outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      led_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
      ledr_q   <= '0;
      for (int unsigned i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      led_q    <= led_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= ~KEY;
      key_s2_q <= key_s1_q;
      ledr_q   <= led_d;
      for (int unsigned i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign LEDR  = ledr_q;
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[5];

endmodule
